breadboard_tester: RTL and testbench

BREADBOARD_TESTER -- requirements
Module: breadboard_tester

---
 rtl/breadboard_tester.sv | 187 ++++++++++++++++++
 tb/tb_breadboard_tester.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/breadboard_tester.sv
// Sweeps all 16 input combinations through a breadboarded unit, compares each response
// against golden masks and reports pass/fail. Optional fail map: BREADBOARD_TESTER_FAILMAP_EN.
module breadboard_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic        r6,
    input  logic        r7,
    input  logic        r8,
    input  logic        r9,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx
`ifdef BREADBOARD_TESTER_FAILMAP_EN
    ,
    output logic [15:0] fail_map
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] F6 = 16'h212E;
    localparam logic [15:0] F7 = 16'h1668;
    localparam logic [15:0] F8 = 16'h8888;
    localparam logic [15:0] F9 = 16'h6996;

    localparam logic [4:0] SETTLE_W = 5'(SETTLE_CYCLES);
    // With no settle time each vector goes straight to its sample cycle.
    localparam state_t S_ENTRY = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    function automatic logic [3:0] golden_resp(input logic [3:0] v);
        return {F6[v], F7[v], F8[v], F9[v]};
    endfunction

    state_t      r_state, w_state_nx;
    logic [4:0]  r_idx, w_idx_nx;
    logic [3:0]  r_cnt, w_cnt_nx;
    logic [3:0]  r_vec, w_vec_nx;
    logic        r_busy, w_busy_nx;
    logic        r_done, w_done_nx;
    logic        r_pass, w_pass_nx;
    logic [4:0]  r_err, w_err_nx;
    logic [3:0]  r_first, w_first_nx;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
    logic [15:0] r_fmap, w_fmap_nx;
`endif

    logic [4:0]  w_cnt_inc;
    logic        w_mismatch;

    assign w_cnt_inc  = {1'b0, r_cnt} + 5'd1;
    assign w_mismatch = ({r6, r7, r8, r9} != golden_resp(r_idx[3:0]));

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_vec_nx   = r_vec;
        w_busy_nx  = r_busy;
        w_done_nx  = r_done;
        w_pass_nx  = r_pass;
        w_err_nx   = r_err;
        w_first_nx = r_first;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
        w_fmap_nx  = r_fmap;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nx = S_ENTRY;
                    w_idx_nx   = 5'd0;
                    w_cnt_nx   = 4'd0;
                    w_vec_nx   = 4'd0;
                    w_busy_nx  = 1'b1;
                    w_done_nx  = 1'b0;
                    w_pass_nx  = 1'b0;
                    w_err_nx   = 5'd0;
                    w_first_nx = 4'd0;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
                    w_fmap_nx  = 16'h0000;
`endif
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_SETTLE: begin
                if (w_cnt_inc == SETTLE_W) begin
                    w_state_nx = S_SAMPLE;
                    w_cnt_nx   = 4'd0;
                end else begin
                    w_cnt_nx   = w_cnt_inc[3:0];
                end
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nx = r_err + 5'd1;
                    if (r_err == 5'd0) begin
                        w_first_nx = r_idx[3:0];
                    end else begin
                        w_first_nx = r_first;
                    end
`ifdef BREADBOARD_TESTER_FAILMAP_EN
                    w_fmap_nx[r_idx[3:0]] = 1'b1;
`endif
                end else begin
                    w_err_nx = r_err;
                end
                // The 5-bit index steps to 16 after the last vector, so it never wraps to 0.
                w_idx_nx = r_idx + 5'd1;
                if (r_idx == 5'd15) begin
                    w_state_nx = S_DONE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_pass_nx  = (r_err == 5'd0) && !w_mismatch;
                end else begin
                    w_state_nx = S_ENTRY;
                    w_vec_nx   = w_idx_nx[3:0];
                    w_cnt_nx   = 4'd0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
                w_done_nx  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_cnt   <= 4'd0;
            r_vec   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 5'd0;
            r_first <= 4'd0;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
            r_fmap  <= 16'h0000;
`endif
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_vec   <= w_vec_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_pass  <= w_pass_nx;
            r_err   <= w_err_nx;
            r_first <= w_first_nx;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
            r_fmap  <= w_fmap_nx;
`endif
        end
    end

    assign w             = r_vec[3];
    assign x             = r_vec[2];
    assign y             = r_vec[1];
    assign z             = r_vec[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign first_err_idx = r_first;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
    assign fail_map      = r_fmap;
`endif

endmodule

// File: tb/tb_breadboard_tester.sv
// Self-checking bench for breadboard_tester: two instances (SETTLE_CYCLES=2 and 0), a table of
// responder faults plus randomized faults scored by an independent per-vector model.
module tb_breadboard_tester;

    localparam int S_A = 2;
    localparam int S_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_start, b_start;
    logic a_w, a_x, a_y, a_z, b_w, b_x, b_y, b_z;
    logic a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [4:0] a_err, b_err;
    logic [3:0] a_first, b_first;
    logic [3:0] a_vec, b_vec, a_resp, b_resp;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
    logic [15:0] a_fmap, b_fmap;
`endif

    // Responder: golden truth table, then faults (AND/OR ties and per-vector XOR corruption).
    logic [3:0] gold_tab [16];
    logic [3:0] xor_tab  [16];
    logic [3:0] and_m, or_m;

    assign a_vec  = {a_w, a_x, a_y, a_z};
    assign b_vec  = {b_w, b_x, b_y, b_z};
    assign a_resp = ((gold_tab[a_vec] & and_m) | or_m) ^ xor_tab[a_vec];
    assign b_resp = ((gold_tab[b_vec] & and_m) | or_m) ^ xor_tab[b_vec];

    breadboard_tester #(.SETTLE_CYCLES(S_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .w(a_w), .x(a_x), .y(a_y), .z(a_z),
        .r6(a_resp[3]), .r7(a_resp[2]), .r8(a_resp[1]), .r9(a_resp[0]),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_err_idx(a_first)
`ifdef BREADBOARD_TESTER_FAILMAP_EN
        , .fail_map(a_fmap)
`endif
    );

    breadboard_tester #(.SETTLE_CYCLES(S_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .w(b_w), .x(b_x), .y(b_y), .z(b_z),
        .r6(b_resp[3]), .r7(b_resp[2]), .r8(b_resp[1]), .r9(b_resp[0]),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_err_idx(b_first)
`ifdef BREADBOARD_TESTER_FAILMAP_EN
        , .fail_map(b_fmap)
`endif
    );

    // Selected-instance view so one set of tasks drives either DUT.
    logic sel;
    logic m_busy, m_done, m_pass;
    logic [4:0] m_err;
    logic [3:0] m_first, m_vec;
    logic [15:0] m_fmap;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_pass  = sel ? b_pass  : a_pass;
    assign m_err   = sel ? b_err   : a_err;
    assign m_first = sel ? b_first : a_first;
    assign m_vec   = sel ? b_vec   : a_vec;
`ifdef BREADBOARD_TESTER_FAILMAP_EN
    assign m_fmap  = sel ? b_fmap  : a_fmap;
`else
    assign m_fmap  = 16'h0000;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) b_start = v;
        else     a_start = v;
    endtask

    function automatic int settle_of(input logic s);
        return s ? S_B : S_A;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},  32'(m_busy),  32'd0);
        chk({tag, " done"},  32'(m_done),  32'd0);
        chk({tag, " pass"},  32'(m_pass),  32'd0);
        chk({tag, " err"},   32'(m_err),   32'd0);
        chk({tag, " first"}, 32'(m_first), 32'd0);
        chk({tag, " vec"},   32'(m_vec),   32'd0);
        chk({tag, " fmap"},  32'(m_fmap),  32'd0);
    endtask

    // Checks the per-cycle vector sequence and busy length from the first cycle after acceptance.
    task automatic follow_sweep(input string tag);
        int s, k;
        s = settle_of(sel);
        k = 0;
        while (m_busy && k < 1000) begin
            chk({tag, " vec seq"}, 32'(m_vec), 32'(k / (s + 1)));
            k++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 32'(k), 32'(16 * (s + 1)));
    endtask

    task automatic chk_result(input string tag, input int e_err, input int e_first,
                              input logic e_pass, input logic [15:0] e_fmap);
        chk({tag, " done"},  32'(m_done),  32'd1);
        chk({tag, " err"},   32'(m_err),   32'(e_err));
        chk({tag, " first"}, 32'(m_first), 32'(e_first));
        chk({tag, " pass"},  32'(m_pass),  32'(e_pass));
        chk({tag, " vecF"},  32'(m_vec),   32'hF);
`ifdef BREADBOARD_TESTER_FAILMAP_EN
        chk({tag, " fmap"},  32'(m_fmap),  32'(e_fmap));
`else
        if (e_fmap != 16'h0000 && m_fmap != 16'h0000) chk({tag, " fmap"}, 32'(m_fmap), 32'd0);
`endif
    endtask

    task automatic run_sweep(input string tag, input int e_err, input int e_first,
                             input logic e_pass, input logic [15:0] e_fmap);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        follow_sweep(tag);
        chk_result(tag, e_err, e_first, e_pass, e_fmap);
        repeat (3) @(negedge clk);
        chk_result({tag, " hold"}, e_err, e_first, e_pass, e_fmap);
    endtask

    typedef struct {
        logic [3:0]  and_m;
        logic [3:0]  or_m;
        logic [3:0]  xor_all;
        bit          rnd;
        int          e_err;
        int          e_first;
        logic        e_pass;
        logic [15:0] e_fmap;
    } row_t;

    row_t rows [7];

    // Reference: a vector fails when the faulted response differs from the golden one.
    task automatic model(output int e_err, output int e_first, output logic e_pass,
                         output logic [15:0] e_fmap);
        logic [3:0] got;
        e_err = 0; e_first = 0; e_fmap = 16'h0000;
        for (int v = 0; v < 16; v++) begin
            got = ((gold_tab[v] & and_m) | or_m) ^ xor_tab[v];
            if (got != gold_tab[v]) begin
                if (e_err == 0) e_first = v;
                e_err++;
                e_fmap[v] = 1'b1;
            end
        end
        e_pass = (e_err == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f6, f7, f8, f9;
        int k, e_err, e_first;
        logic e_pass;
        logic [15:0] e_fmap;
        f6 = 16'h212E; f7 = 16'h1668; f8 = 16'h8888; f9 = 16'h6996;
        for (int v = 0; v < 16; v++) begin
            gold_tab[v] = {f6[v], f7[v], f8[v], f9[v]};
            xor_tab[v]  = 4'h0;
        end
        and_m = 4'hF; or_m = 4'h0;

        rows[0] = '{4'hF, 4'h0, 4'h0, 1'b0, 0,  0, 1'b1, 16'h0000};
        rows[1] = '{4'hD, 4'h0, 4'h0, 1'b0, 4,  3, 1'b0, 16'h8888};
        rows[2] = '{4'hF, 4'h0, 4'h1, 1'b0, 16, 0, 1'b0, 16'hFFFF};
        rows[3] = '{4'hF, 4'h8, 4'h0, 1'b0, 10, 0, 1'b0, 16'hDED1};
        rows[4] = '{4'hF, 4'h0, 4'h0, 1'b1, 0,  0, 1'b0, 16'h0000};
        rows[5] = '{4'hF, 4'h0, 4'h0, 1'b1, 0,  0, 1'b0, 16'h0000};
        rows[6] = '{4'hF, 4'h0, 4'h0, 1'b1, 0,  0, 1'b0, 16'h0000};

        sel = 1'b0; a_start = 1'b0; b_start = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset A");
        sel = 1'b1;
        chk_idle("reset B");
        rst_n = 1'b1;

        for (int si = 0; si < 2; si++) begin
            sel = si[0];
            for (int r = 0; r < 7; r++) begin
                and_m = rows[r].and_m;
                or_m  = rows[r].or_m;
                for (int v = 0; v < 16; v++) begin
                    if (rows[r].rnd) xor_tab[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                    else             xor_tab[v] = rows[r].xor_all;
                end
                if (rows[r].rnd) model(e_err, e_first, e_pass, e_fmap);
                else begin
                    e_err = rows[r].e_err; e_first = rows[r].e_first;
                    e_pass = rows[r].e_pass; e_fmap = rows[r].e_fmap;
                end
                run_sweep($sformatf("row%0d dut%0d", r, si), e_err, e_first, e_pass, e_fmap);
            end
        end

        // Reset during vector 7, with start asserted on the same edge.
        sel = 1'b0; and_m = 4'hF; or_m = 4'hF;
        for (int v = 0; v < 16; v++) xor_tab[v] = 4'h0;
        or_m = 4'h0;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        k = 0;
        while (a_vec != 4'd7 && k < 200) begin k++; @(negedge clk); end
        chk("midreset reach vec7", 32'(a_vec), 32'd7);
        rst_n = 1'b0; a_start = 1'b1;
        @(negedge clk);
        chk_idle("midreset");
        rst_n = 1'b1; a_start = 1'b0;
        @(negedge clk);
        chk_idle("after reset");
        run_sweep("post reset", 0, 0, 1'b1, 16'h0000);

        // Start held high across the sweep: one sweep, then restart on the first DONE edge.
        for (int si = 0; si < 2; si++) begin
            sel = si[0];
            xor_tab[5] = 4'h2;
            @(negedge clk); set_start(1'b1);
            @(negedge clk);
            follow_sweep($sformatf("held dut%0d", si));
            chk_result($sformatf("held dut%0d", si), 1, 5, 1'b0, 16'h0020);
            @(negedge clk);
            chk($sformatf("restart busy dut%0d", si), 32'(m_busy), 32'd1);
            chk($sformatf("restart done dut%0d", si), 32'(m_done), 32'd0);
            chk($sformatf("restart err dut%0d", si),  32'(m_err),  32'd0);
            chk($sformatf("restart vec dut%0d", si),  32'(m_vec),  32'd0);
            set_start(1'b0);
            xor_tab[5] = 4'h0;
            k = 0;
            while (m_busy && k < 200) begin k++; @(negedge clk); end
            chk_result($sformatf("restart end dut%0d", si), 0, 0, 1'b1, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
